omsp_spm_cmd_seq: RTL and testbench

//  Sequencer between the execution unit and omsp_spm_control for Sancus SPM instructions
//  (protect, unprotect, get-id, read-field). Accepts one command via valid/ready, drives the

---
 rtl/omsp_spm_cmd_seq_pkg.sv | 35 +++
 rtl/omsp_spm_cmd_seq_if.sv | 37 +++
 rtl/omsp_spm_cmd_seq.sv | 160 ++++++++++++++++
 tb/tb_omsp_spm_cmd_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_spm_cmd_seq_pkg.sv
// Shared opcode/request encodings and helpers for the Sancus SPM command sequencer.
// Encodings track the core defines so the sequencer stays drop-in compatible.
package omsp_spm_cmd_seq_pkg;

  typedef enum logic [2:0] {
    SPM_OP_PROTECT    = 3'd0,
    SPM_OP_UNPROTECT  = 3'd1,
    SPM_OP_GET_ID     = 3'd2,
    SPM_OP_READ_FIELD = 3'd3
  } spm_op_e;

  typedef enum logic [2:0] {
    SPM_REQ_NONE      = 3'd0,
    SPM_REQ_ID        = 3'd1,
    SPM_REQ_PUB_START = 3'd2,
    SPM_REQ_PUB_END   = 3'd3,
    SPM_REQ_SEC_START = 3'd4,
    SPM_REQ_SEC_END   = 3'd5
  } spm_req_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] arg;
    logic [2:0]  req;
  } spm_cmd_t;

  // Only READ_FIELD forwards the caller's field code; every other readback asks for the ID.
  function automatic logic [2:0] spm_req_for(input logic [2:0] op, input logic [2:0] field);
    logic [2:0] req;
    req = SPM_REQ_ID;
    if (op == SPM_OP_READ_FIELD) req = field;
    return req;
  endfunction

endpackage

// File: rtl/omsp_spm_cmd_seq_if.sv
// EU command handshake plus omsp_spm_control sideband, seen from the sequencer.
// master = EU / spm control environment, slave = the sequencer.
interface omsp_spm_cmd_seq_if;

  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [2:0]  cmd_field;
  logic        cmd_ready;
  logic        cmd_done;
  logic        cmd_ok;
  logic [15:0] cmd_result;
  logic        eu_stall;

  logic        update_spm;
  logic        enable_spm;
  logic [15:0] spm_select;
  logic [2:0]  data_request;
  logic        violation;
  logic        spm_select_valid;
  logic [15:0] requested_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_field,
    output violation, spm_select_valid, requested_data,
    input  cmd_ready, cmd_done, cmd_ok, cmd_result, eu_stall,
    input  update_spm, enable_spm, spm_select, data_request
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_field,
    input  violation, spm_select_valid, requested_data,
    output cmd_ready, cmd_done, cmd_ok, cmd_result, eu_stall,
    output update_spm, enable_spm, spm_select, data_request
  );

endinterface

// File: rtl/omsp_spm_cmd_seq.sv
// Sancus SPM command sequencer: one command at a time from the EU to omsp_spm_control.
// state  | meaning
// IDLE   | ready for a command
// UPDATE | one-cycle update_spm pulse (protect/unprotect)
// CHECK  | sample violation from spm control
// READ   | hold select/request for READ_WAIT cycles, then sample readback
// DONE   | one-cycle result pulse
module omsp_spm_cmd_seq
  import omsp_spm_cmd_seq_pkg::*;
#(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic                mclk,
  input  logic                puc_rst,
  omsp_spm_cmd_seq_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UPDATE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  spm_cmd_t    cmd_q, cmd_d;
  logic        ok_q, ok_d;
  logic [15:0] result_q, result_d;

  logic        ready_q, ready_d;
  logic        update_q, update_d;
  logic        enable_q, enable_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] select_q, select_d;
  logic [2:0]  req_q, req_d;

  logic        accept;

  assign accept = bus.cmd_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cmd_d    = cmd_q;
    ok_d     = ok_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.op  = bus.cmd_op;
          cmd_d.arg = bus.cmd_arg;
          cmd_d.req = spm_req_for(bus.cmd_op, bus.cmd_field);
          case (bus.cmd_op)
            SPM_OP_PROTECT, SPM_OP_UNPROTECT: state_d = ST_UPDATE;
            SPM_OP_GET_ID, SPM_OP_READ_FIELD: begin
              state_d = ST_READ;
              wait_d  = WAIT_LOAD;
            end
            default: begin
              state_d  = ST_DONE;
              ok_d     = 1'b0;
              result_d = 16'h0000;
            end
          endcase
        end
      end

      ST_UPDATE: state_d = ST_CHECK;

      ST_CHECK: begin
        if (cmd_q.op == SPM_OP_PROTECT) begin
          if (bus.violation) begin
            state_d  = ST_DONE;
            ok_d     = 1'b0;
            result_d = 16'h0000;
          end else begin
            state_d = ST_READ;
            wait_d  = WAIT_LOAD;
          end
        end else begin
          state_d  = ST_DONE;
          ok_d     = 1'b1;
          result_d = 16'h0000;
        end
      end

      ST_READ: begin
        if (wait_q == 3'd0) begin
          state_d  = ST_DONE;
          ok_d     = bus.spm_select_valid;
          result_d = bus.spm_select_valid ? bus.requested_data : 16'h0000;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ready_d  = (state_d == ST_IDLE);
    update_d = (state_d == ST_UPDATE);
    enable_d = ((state_d == ST_UPDATE) || (state_d == ST_CHECK)) &&
               (cmd_d.op == SPM_OP_PROTECT);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
    select_d = (state_d == ST_READ) ? cmd_d.arg : 16'h0000;
    req_d    = (state_d == ST_READ) ? cmd_d.req : 3'd0;
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= 3'd0;
      cmd_q    <= '0;
      ok_q     <= 1'b0;
      result_q <= 16'h0000;
      ready_q  <= 1'b1;
      update_q <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      select_q <= 16'h0000;
      req_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cmd_q    <= cmd_d;
      ok_q     <= ok_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      update_q <= update_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      select_q <= select_d;
      req_q    <= req_d;
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.cmd_done     = done_q;
  assign bus.cmd_ok       = ok_q;
  assign bus.cmd_result   = result_q;
  // The EU must freeze in the very cycle it hands over a command, hence the accept term.
  assign bus.eu_stall     = busy_q | accept;
  assign bus.update_spm   = update_q;
  assign bus.enable_spm   = enable_q;
  assign bus.spm_select   = select_q;
  assign bus.data_request = req_q;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Randomized bench for omsp_spm_cmd_seq: two instances (READ_WAIT 1 and 3) against a
// transaction-level model of latency, status, result and sideband activity.
module tb_omsp_spm_cmd_seq;

  logic mclk;
  logic puc_rst;
  logic sel;

  logic        cmd_valid_r;
  logic [2:0]  cmd_op_r;
  logic [15:0] cmd_arg_r;
  logic [2:0]  cmd_field_r;
  logic        violation_r;
  logic        sv_r;
  logic [15:0] data_r;

  int n_checks;
  int n_fail;

  logic        prev_ok [2];
  logic [15:0] prev_res [2];

  omsp_spm_cmd_seq_if bus1();
  omsp_spm_cmd_seq_if bus3();

  omsp_spm_cmd_seq #(.READ_WAIT(1)) dut1 (.mclk(mclk), .puc_rst(puc_rst), .bus(bus1));
  omsp_spm_cmd_seq #(.READ_WAIT(3)) dut3 (.mclk(mclk), .puc_rst(puc_rst), .bus(bus3));

  assign bus1.cmd_valid        = cmd_valid_r & ~sel;
  assign bus3.cmd_valid        = cmd_valid_r & sel;
  assign bus1.cmd_op           = cmd_op_r;
  assign bus3.cmd_op           = cmd_op_r;
  assign bus1.cmd_arg          = cmd_arg_r;
  assign bus3.cmd_arg          = cmd_arg_r;
  assign bus1.cmd_field        = cmd_field_r;
  assign bus3.cmd_field        = cmd_field_r;
  assign bus1.violation        = violation_r;
  assign bus3.violation        = violation_r;
  assign bus1.spm_select_valid = sv_r;
  assign bus3.spm_select_valid = sv_r;
  assign bus1.requested_data   = data_r;
  assign bus3.requested_data   = data_r;

  logic        o_ready, o_done, o_ok, o_stall, o_update, o_enable;
  logic [15:0] o_result, o_select;
  logic [2:0]  o_req;

  assign o_ready  = sel ? bus3.cmd_ready    : bus1.cmd_ready;
  assign o_done   = sel ? bus3.cmd_done     : bus1.cmd_done;
  assign o_ok     = sel ? bus3.cmd_ok       : bus1.cmd_ok;
  assign o_result = sel ? bus3.cmd_result   : bus1.cmd_result;
  assign o_stall  = sel ? bus3.eu_stall     : bus1.eu_stall;
  assign o_update = sel ? bus3.update_spm   : bus1.update_spm;
  assign o_enable = sel ? bus3.enable_spm   : bus1.enable_spm;
  assign o_select = sel ? bus3.spm_select   : bus1.spm_select;
  assign o_req    = sel ? bus3.data_request : bus1.data_request;

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_zero"}, {o_done, o_ok, o_stall, o_update, o_enable, o_result, o_select, o_req},
        32'd0);
  endtask

  // One command, expectations derived from the command rules alone.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] arg, input logic [2:0] field,
                         input logic viol, input logic sv, input logic [15:0] data,
                         input bit hold);
    int          s, rw, exp_lat, exp_upd, exp_en, exp_rd;
    logic        exp_ok;
    logic [15:0] exp_res;
    logic [2:0]  exp_req;
    int          lat, upd, upd_at, en_cnt, rd, req_bad, rdy_bad, stall_bad, held_bad;
    logic        en_at_upd;

    s  = int'(sel);
    rw = sel ? 3 : 1;
    exp_req = (op == 3'd3) ? field : 3'd1;
    exp_upd = (op <= 3'd1) ? 1 : 0;
    exp_en  = (op == 3'd0) ? 2 : 0;
    case (op)
      3'd0: begin
        if (viol) begin
          exp_lat = 3; exp_ok = 1'b0; exp_res = 16'h0; exp_rd = 0;
        end else begin
          exp_lat = 3 + rw; exp_ok = sv; exp_res = sv ? data : 16'h0; exp_rd = rw;
        end
      end
      3'd1:       begin exp_lat = 3;      exp_ok = 1'b1; exp_res = 16'h0;             exp_rd = 0;  end
      3'd2, 3'd3: begin exp_lat = 1 + rw; exp_ok = sv;   exp_res = sv ? data : 16'h0; exp_rd = rw; end
      default:    begin exp_lat = 1;      exp_ok = 1'b0; exp_res = 16'h0;             exp_rd = 0;  end
    endcase

    lat = 0; upd = 0; upd_at = 0; en_cnt = 0; rd = 0;
    req_bad = 0; rdy_bad = 0; stall_bad = 0; held_bad = 0; en_at_upd = 1'b0;

    @(negedge mclk);
    cmd_op_r = op; cmd_arg_r = arg; cmd_field_r = field;
    violation_r = viol; sv_r = sv; data_r = data;
    cmd_valid_r = 1'b1;
    #1;
    chk("ready_at_issue", {31'd0, o_ready}, 32'd1);
    chk("stall_at_accept", {31'd0, o_stall}, 32'd1);

    for (int c = 1; c <= 24 && lat == 0; c++) begin
      @(negedge mclk);
      if (o_update) begin upd++; upd_at = c; en_at_upd = o_enable; end
      if (o_enable) en_cnt++;
      if (o_select == arg) begin
        rd++;
        if (o_req !== exp_req) req_bad++;
      end else if (o_select != 16'h0 || o_req != 3'd0) req_bad++;
      if (!o_stall) stall_bad++;
      if (o_done) lat = c;
      else begin
        if (o_ready) rdy_bad++;
        if (o_ok !== prev_ok[s] || o_result !== prev_res[s]) held_bad++;
      end
      if (!hold) cmd_valid_r = 1'b0;
    end

    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", lat, exp_lat);
    chk("ok", {31'd0, o_ok}, {31'd0, exp_ok});
    chk("result", {16'd0, o_result}, {16'd0, exp_res});
    chk("update_count", upd, exp_upd);
    chk("update_cycle", upd_at, exp_upd);
    chk("enable_in_update", {31'd0, en_at_upd}, {31'd0, (op == 3'd0)});
    chk("enable_cycles", en_cnt, exp_en);
    chk("read_cycles", rd, exp_rd);
    chk("request_errors", req_bad, 0);
    chk("ready_while_busy", rdy_bad, 0);
    chk("stall_gaps", stall_bad, 0);
    chk("status_held_busy", held_bad, 0);

    @(negedge mclk);
    chk("ready_after_done", {31'd0, o_ready}, 32'd1);
    chk("quiet_after_done", {o_done, o_update, o_enable, o_select, o_req}, 32'd0);
    chk("status_held_after", {15'd0, o_ok, o_result}, {15'd0, exp_ok, exp_res});
    chk("stall_after_done", {31'd0, o_stall}, {31'd0, hold});
    cmd_valid_r = 1'b0;
    prev_ok[s]  = exp_ok;
    prev_res[s] = exp_res;
  endtask

  // Reset during UPDATE (k=1) or CHECK (k=2), then confirm a clean recovery.
  task automatic reset_mid(input logic [2:0] op, input int k);
    int upd;
    upd = 0;
    @(negedge mclk);
    cmd_op_r = op; cmd_arg_r = 16'h1234; cmd_field_r = 3'd0;
    violation_r = 1'b0; sv_r = 1'b1; data_r = 16'h00AA;
    cmd_valid_r = 1'b1;
    for (int c = 1; c <= k; c++) begin
      @(negedge mclk);
      cmd_valid_r = 1'b0;
    end
    if (k == 1) chk("update_before_reset", {31'd0, o_update}, 32'd1);
    #2 puc_rst = 1'b1;
    #1;
    chk_idle_outputs("reset_mid");
    for (int c = 0; c < 2; c++) begin
      @(negedge mclk);
      if (bus1.update_spm || bus3.update_spm) upd++;
    end
    puc_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge mclk);
      if (bus1.update_spm || bus3.update_spm) upd++;
    end
    chk("update_after_reset", upd, 0);
    prev_ok[0] = 1'b0; prev_ok[1] = 1'b0;
    prev_res[0] = 16'h0; prev_res[1] = 16'h0;
    run_cmd(3'd2, 16'h8000, 3'd0, 1'b0, 1'b1, 16'h0042, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [15:0] arg;
    n_checks = 0;
    n_fail   = 0;
    sel = 1'b0;
    cmd_valid_r = 1'b0; cmd_op_r = 3'd0; cmd_arg_r = 16'h0; cmd_field_r = 3'd0;
    violation_r = 1'b0; sv_r = 1'b0; data_r = 16'h0;
    prev_ok[0] = 1'b0; prev_ok[1] = 1'b0;
    prev_res[0] = 16'h0; prev_res[1] = 16'h0;

    puc_rst = 1'b0;
    #2 puc_rst = 1'b1;
    #20;
    sel = 1'b0; #1 chk_idle_outputs("reset1");
    sel = 1'b1; #1 chk_idle_outputs("reset3");
    sel = 1'b0;
    @(negedge mclk);
    puc_rst = 1'b0;

    run_cmd(3'd2, 16'h8000, 3'd0, 1'b0, 1'b1, 16'h0005, 1'b0);
    run_cmd(3'd0, 16'h8000, 3'd0, 1'b0, 1'b1, 16'h0007, 1'b0);
    run_cmd(3'd0, 16'h8000, 3'd0, 1'b1, 1'b1, 16'h0007, 1'b0);
    run_cmd(3'd1, 16'h8000, 3'd0, 1'b1, 1'b1, 16'h0007, 1'b1);
    sel = 1'b1;
    run_cmd(3'd3, 16'h4000, 3'd4, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    run_cmd(3'd6, 16'h4000, 3'd4, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    run_cmd(3'd0, 16'h2222, 3'd0, 1'b0, 1'b1, 16'hC0DE, 1'b1);
    sel = 1'b0;
    reset_mid(3'd0, 1);
    reset_mid(3'd1, 2);
    sel = 1'b1;
    reset_mid(3'd0, 2);

    for (int i = 0; i < 40; i++) begin
      @(negedge mclk);
      sel = 1'($urandom_range(0, 1));
      op  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      arg = 16'($urandom) | 16'h0001;
      run_cmd(op, arg, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
